// File: rtl/mac_relu_pipeline.sv
// Dense-layer engine: streams N_HIDDEN x N_IN weights from a 1-cycle-latency RAM, accumulates
// each neuron's dot product over P interleaved partial sums, and emits ReLU(sum) per neuron.
module mac_relu_pipeline #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned N_IN     = 8,
   parameter int unsigned N_HIDDEN = 4,
   parameter int unsigned P        = 2,
   localparam int unsigned ACC_W   = 2 * DATA_W + $clog2(N_IN > 2 ? N_IN : 2),
   localparam int unsigned AW      = $clog2(N_HIDDEN * N_IN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_compute,
   input  logic [N_IN*DATA_W-1:0]   invec_bus,
   output logic [AW-1:0]            wmem_raddr,
   input  logic signed [DATA_W-1:0] wmem_rdata,
   output logic signed [ACC_W-1:0]  out_data,
   output logic                     out_valid,
   output logic                     busy
);

   localparam int unsigned IW = $clog2(N_IN > 2 ? N_IN : 2);
   localparam int unsigned PW = $clog2(P > 2 ? P : 2);
   localparam logic [AW-1:0] LastAddr = AW'(N_HIDDEN * N_IN - 1);
   localparam logic [IW-1:0] LastElem = IW'(N_IN - 1);
   localparam logic [PW-1:0] LastPart = PW'(P - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                     state_q;
   logic                       busy_q;
   logic                       launch_q;
   logic                       issue_q;
   logic [AW-1:0]              raddr_q;
   logic [IW-1:0]              elem_q;
   logic [PW-1:0]              part_q;
   logic signed [DATA_W-1:0]   invec_q [N_IN];

   logic                       s1_valid_q;
   logic [IW-1:0]              s1_elem_q;
   logic [PW-1:0]              s1_part_q;
   logic                       s1_last_elem_q;
   logic                       s1_last_neuron_q;
   logic signed [ACC_W-1:0]    acc_q [P];
   logic signed [ACC_W-1:0]    mac_q;
   logic                       mac_valid_q;
   logic                       mac_last_q;
   logic signed [ACC_W-1:0]    out_data_q;
   logic                       out_valid_q;

   logic signed [2*DATA_W-1:0] w_ext, x_ext, prod;
   logic signed [ACC_W-1:0]    prod_ext, mac_sum;

   // Control FSM: latch inputs on start, then issue one weight address per cycle.
   // launch_q delays the first address by one cycle so busy and address 0 appear together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         busy_q   <= 1'b0;
         launch_q <= 1'b0;
         issue_q  <= 1'b0;
         raddr_q  <= '0;
         elem_q   <= '0;
         part_q   <= '0;
      end else begin
         busy_q <= (state_q == StRun);
         unique case (state_q)
            StIdle: begin
               if (start_compute && !busy_q) begin
                  state_q  <= StRun;
                  launch_q <= 1'b1;
                  for (int i = 0; i < N_IN; i++) begin
                     invec_q[i] <= invec_bus[i*DATA_W +: DATA_W];
                  end
               end
            end
            StRun: begin
               if (launch_q) begin
                  launch_q <= 1'b0;
                  issue_q  <= 1'b1;
                  raddr_q  <= '0;
                  elem_q   <= '0;
                  part_q   <= '0;
               end else if (issue_q) begin
                  if (raddr_q == LastAddr) begin
                     issue_q <= 1'b0;
                  end else begin
                     raddr_q <= raddr_q + AW'(1);
                  end
                  if (elem_q == LastElem) begin
                     elem_q <= '0;
                     part_q <= '0;
                  end else begin
                     elem_q <= elem_q + IW'(1);
                     part_q <= (part_q == LastPart) ? '0 : part_q + PW'(1);
                  end
               end
               // Leave RUN as the last result is registered; busy_q trails by one cycle.
               if (mac_valid_q && mac_last_q) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Product of the returning weight with its input element, and the neuron's final sum.
   always_comb begin
      w_ext    = {{DATA_W{wmem_rdata[DATA_W-1]}}, wmem_rdata};
      x_ext    = {{DATA_W{invec_q[s1_elem_q][DATA_W-1]}}, invec_q[s1_elem_q]};
      prod     = w_ext * x_ext;
      prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
      mac_sum  = prod_ext;
      for (int p = 0; p < P; p++) begin
         mac_sum = mac_sum + acc_q[p];
      end
   end

   // Datapath: tag stage aligned with RAM latency, partial accumulation, MAC and ReLU registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q       <= 1'b0;
         s1_elem_q        <= '0;
         s1_part_q        <= '0;
         s1_last_elem_q   <= 1'b0;
         s1_last_neuron_q <= 1'b0;
         for (int p = 0; p < P; p++) begin
            acc_q[p] <= '0;
         end
         mac_q       <= '0;
         mac_valid_q <= 1'b0;
         mac_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         s1_valid_q       <= issue_q;
         s1_elem_q        <= elem_q;
         s1_part_q        <= part_q;
         s1_last_elem_q   <= (elem_q == LastElem);
         s1_last_neuron_q <= (raddr_q == LastAddr);
         mac_valid_q      <= 1'b0;
         if (s1_valid_q) begin
            if (s1_last_elem_q) begin
               mac_q       <= mac_sum;
               mac_valid_q <= 1'b1;
               mac_last_q  <= s1_last_neuron_q;
               for (int p = 0; p < P; p++) begin
                  acc_q[p] <= '0;
               end
            end else begin
               acc_q[s1_part_q] <= acc_q[s1_part_q] + prod_ext;
            end
         end
         out_valid_q <= mac_valid_q;
         if (mac_valid_q) begin
            out_data_q <= mac_q[ACC_W-1] ? '0 : mac_q;
         end
      end
   end

   assign wmem_raddr = raddr_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mac_relu_pipeline.sv
// Directed bench for mac_relu_pipeline with a registered weight RAM model.
module tb_mac_relu_pipeline;

   localparam int DATA_W   = 8;
   localparam int N_IN     = 8;
   localparam int N_HIDDEN = 4;
   localparam int ACC_W    = 19;
   localparam int AW       = 5;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start_compute;
   logic [N_IN*DATA_W-1:0]   invec_bus;
   logic [AW-1:0]            wmem_raddr;
   logic signed [DATA_W-1:0] wmem_rdata;
   logic signed [ACC_W-1:0]  out_data;
   logic                     out_valid;
   logic                     busy;

   logic signed [DATA_W-1:0] wmem [N_HIDDEN*N_IN];
   logic signed [DATA_W-1:0] in_vec [N_IN];
   longint                   exp_out [N_HIDDEN];
   int                       n_pass  = 0;
   int                       n_total = 0;

   always #5 clk = ~clk;

   mac_relu_pipeline #(
      .DATA_W   (DATA_W),
      .N_IN     (N_IN),
      .N_HIDDEN (N_HIDDEN),
      .P        (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_compute (start_compute),
      .invec_bus     (invec_bus),
      .wmem_raddr    (wmem_raddr),
      .wmem_rdata    (wmem_rdata),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .busy          (busy)
   );

   // Weight RAM: data appears the cycle after the address.
   always @(posedge clk) wmem_rdata <= wmem[wmem_raddr];

   task automatic check(input string tag, input longint got, input longint exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic set_rows(input int w0, input int w1, input int w2, input int w3);
      for (int i = 0; i < N_IN; i++) begin
         wmem[i]          = DATA_W'(w0);
         wmem[N_IN+i]     = DATA_W'(w1);
         wmem[2*N_IN+i]   = DATA_W'(w2);
         wmem[3*N_IN+i]   = DATA_W'(w3);
      end
   endtask

   task automatic set_inputs(input int v);
      for (int i = 0; i < N_IN; i++) in_vec[i] = DATA_W'(v);
   endtask

   task automatic randomize_all();
      for (int i = 0; i < N_HIDDEN * N_IN; i++) wmem[i] = DATA_W'($urandom);
      for (int i = 0; i < N_IN; i++) in_vec[i] = DATA_W'($urandom);
   endtask

   // Software reference: dot product per neuron followed by ReLU.
   task automatic model();
      for (int h = 0; h < N_HIDDEN; h++) begin
         longint s = 0;
         for (int i = 0; i < N_IN; i++) s += longint'(wmem[h*N_IN+i]) * longint'(in_vec[i]);
         exp_out[h] = (s < 0) ? 0 : s;
      end
   endtask

   // One run; cycle n is sampled at the falling edge after rising edge n (edge 0 takes start).
   task automatic run_layer(input string name, input int restart_cyc, input int rst_cyc,
                            input int exp_count, input int exp_fall);
      int n_out = 0;
      int fall  = -1;
      @(negedge clk);
      for (int i = 0; i < N_IN; i++) invec_bus[i*DATA_W +: DATA_W] = in_vec[i];
      start_compute = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 46; n++) begin
         @(negedge clk);
         invec_bus     = {$urandom, $urandom};
         start_compute = (n == restart_cyc);
         rst           = (n == rst_cyc);
         if (out_valid) begin
            if (n_out < exp_count) begin
               check({name, "_data"}, out_data, exp_out[n_out]);
               check({name, "_valid_cycle"}, n, 11 + 8 * n_out);
            end else begin
               check({name, "_extra_valid_cycle"}, n, -1);
            end
            n_out++;
         end
         if (n == 1) check({name, "_busy_cycle1"}, busy, 1);
         if (n >= 1 && fall < 0 && !busy) fall = n;
         if (rst_cyc >= 0 && n == rst_cyc + 1) begin
            check({name, "_raddr_after_rst"}, wmem_raddr, 0);
            check({name, "_data_after_rst"}, out_data, 0);
         end
      end
      start_compute = 1'b0;
      rst           = 1'b0;
      check({name, "_valid_count"}, n_out, exp_count);
      check({name, "_busy_fall_cycle"}, fall, exp_fall);
   endtask

   initial begin
      rst           = 1'b1;
      start_compute = 1'b0;
      invec_bus     = '0;
      for (int i = 0; i < N_HIDDEN * N_IN; i++) wmem[i] = '0;

      // Reset held with random stimulus
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         invec_bus     = {$urandom, $urandom};
         start_compute = 1'($urandom_range(0, 1));
         check("rst_busy", busy, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_out_data", out_data, 0);
         check("rst_raddr", wmem_raddr, 0);
      end
      @(negedge clk);
      rst           = 1'b0;
      start_compute = 1'b0;

      // Basic: inputs 1, row h weights h+1
      set_inputs(1);
      set_rows(1, 2, 3, 4);
      exp_out = '{8, 16, 24, 32};
      run_layer("basic", -1, -1, 4, 36);

      // ReLU clip, including a clipped zero on the last neuron
      set_rows(-1, 2, 3, -5);
      exp_out = '{0, 16, 24, 0};
      run_layer("clip", -1, -1, 4, 36);

      // Extremes
      set_inputs(-128);
      set_rows(-128, -128, -128, -128);
      exp_out = '{131072, 131072, 131072, 131072};
      run_layer("ext_pos", -1, -1, 4, 36);
      set_inputs(127);
      exp_out = '{0, 0, 0, 0};
      run_layer("ext_neg", -1, -1, 4, 36);

      // Random with ignored restart at cycle 5, then a fresh random run
      randomize_all();
      model();
      run_layer("rand_restart", 5, -1, 4, 36);
      randomize_all();
      model();
      run_layer("rand2", -1, -1, 4, 36);

      // Reset mid-run at cycle 15, then a full run
      set_inputs(1);
      set_rows(1, 2, 3, 4);
      exp_out = '{8, 16, 24, 32};
      run_layer("midrst", -1, 15, 1, 16);
      run_layer("after_rst", -1, -1, 4, 36);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
